// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned WORD_BITS = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  function automatic int unsigned offset_w(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int unsigned index_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned num_lines,
                                        input int unsigned line_bytes);
    return addr_w - index_w(num_lines) - offset_w(line_bytes);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read, one word-write, one line-write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 32,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned ADDR_W     = 32,
  localparam int unsigned INDEX_W   = index_w(NUM_LINES),
  localparam int unsigned TAG_W     = tag_w(ADDR_W, NUM_LINES, LINE_BYTES),
  localparam int unsigned WORDS     = LINE_BYTES / 4,
  localparam int unsigned WSEL_W    = offset_w(LINE_BYTES) - 2,
  localparam int unsigned LINE_W    = LINE_BYTES * 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_W-1:0]   rd_idx,
  output logic                 rd_valid_c,
  output logic                 rd_dirty_c,
  output logic [TAG_W-1:0]     rd_tag_c,
  output logic [LINE_W-1:0]    rd_line_c,
  input  logic                 word_we,
  input  logic [INDEX_W-1:0]   word_idx,
  input  logic [WSEL_W-1:0]    word_sel,
  input  logic [WORD_BITS-1:0] word_data,
  input  logic                 line_we,
  input  logic [INDEX_W-1:0]   line_idx,
  input  logic [TAG_W-1:0]     line_tag,
  input  logic [LINE_W-1:0]    line_data,
  input  logic                 clean_we,
  input  logic [INDEX_W-1:0]   clean_idx
);

  logic [NUM_LINES-1:0]                valid_q;
  logic [NUM_LINES-1:0]                dirty_q;
  logic [TAG_W-1:0]                    tag_q  [NUM_LINES];
  logic [WORDS-1:0][WORD_BITS-1:0]     data_q [NUM_LINES];

  assign rd_valid_c = valid_q[rd_idx];
  assign rd_dirty_c = dirty_q[rd_idx];
  assign rd_tag_c   = tag_q[rd_idx];
  assign rd_line_c  = data_q[rd_idx];

  // Status bits are the only state that reset must clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (line_we) begin
        valid_q[line_idx] <= 1'b1;
        dirty_q[line_idx] <= 1'b0;
      end
      if (clean_we) dirty_q[clean_idx] <= 1'b0;
      if (word_we)  dirty_q[word_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end
    if (word_we) data_q[word_idx][word_sel] <= word_data;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: hit detection, miss FSM and line-wide memory handshake.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 32,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned ADDR_W     = 32,
  localparam int unsigned LINE_W    = LINE_BYTES * 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [ADDR_W-1:0]    Addr_i,
  input  logic [WORD_BITS-1:0] Write_Data_i,
  output logic [WORD_BITS-1:0] Read_Data_o,
  output logic                 memStall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_W-1:0]    mem_data_o,
  input  logic [LINE_W-1:0]    mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int unsigned OFFSET_W = offset_w(LINE_BYTES);
  localparam int unsigned INDEX_W  = index_w(NUM_LINES);
  localparam int unsigned TAG_W    = tag_w(ADDR_W, NUM_LINES, LINE_BYTES);
  localparam int unsigned WORDS    = LINE_BYTES / 4;
  localparam int unsigned WSEL_W   = OFFSET_W - 2;

  state_e                          state_q, state_d;
  logic [TAG_W-1:0]                req_tag_q;
  logic [INDEX_W-1:0]              req_idx_q;
  logic                            req_d, we_d;
  logic [ADDR_W-1:0]               addr_d;
  logic [LINE_W-1:0]               data_d;

  logic [TAG_W-1:0]                addr_tag;
  logic [INDEX_W-1:0]              addr_idx;
  logic [WSEL_W-1:0]               addr_word;
  logic                            rd_valid, rd_dirty;
  logic [TAG_W-1:0]                rd_tag;
  logic [LINE_W-1:0]               rd_line;
  logic [WORDS-1:0][WORD_BITS-1:0] line_words;
  logic                            access, hit, miss, ack;
  logic                            word_we, line_we, clean_we;
  logic                            unused_byte_bits;

  assign addr_tag         = Addr_i[ADDR_W-1 -: TAG_W];
  assign addr_idx         = Addr_i[OFFSET_W +: INDEX_W];
  assign addr_word        = Addr_i[2 +: WSEL_W];
  assign unused_byte_bits = ^Addr_i[1:0];

  dcache_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_BYTES (LINE_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk        (clk_i),
    .rst        (rst_i),
    .rd_idx     (addr_idx),
    .rd_valid_c (rd_valid),
    .rd_dirty_c (rd_dirty),
    .rd_tag_c   (rd_tag),
    .rd_line_c  (rd_line),
    .word_we    (word_we),
    .word_idx   (addr_idx),
    .word_sel   (addr_word),
    .word_data  (Write_Data_i),
    .line_we    (line_we),
    .line_idx   (req_idx_q),
    .line_tag   (req_tag_q),
    .line_data  (mem_data_i),
    .clean_we   (clean_we),
    .clean_idx  (req_idx_q)
  );

  assign line_words  = rd_line;
  assign access      = MemRead_i | MemWrite_i;
  assign hit         = access & rd_valid & (rd_tag == addr_tag);
  assign miss        = (state_q == IDLE) & access & ~hit;
  // An ack only counts while a request is actually outstanding.
  assign ack         = mem_ack_i & mem_req_o;
  assign memStall_o  = (state_q != IDLE) | (access & ~hit);
  assign Read_Data_o = ((state_q == IDLE) && MemRead_i && hit) ? line_words[addr_word]
                                                                : '0;

  always_comb begin
    state_d  = state_q;
    req_d    = mem_req_o;
    we_d     = mem_we_o;
    addr_d   = mem_addr_o;
    data_d   = mem_data_o;
    word_we  = 1'b0;
    line_we  = 1'b0;
    clean_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          req_d = 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d = WRITEBACK;
            we_d    = 1'b1;
            addr_d  = {rd_tag, addr_idx, OFFSET_W'(0)};
            data_d  = rd_line;
          end else begin
            state_d = ALLOCATE;
            we_d    = 1'b0;
            addr_d  = {addr_tag, addr_idx, OFFSET_W'(0)};
            data_d  = '0;
          end
        end else if (hit && MemWrite_i) begin
          word_we = 1'b1;
        end
      end
      WRITEBACK: begin
        if (ack) begin
          clean_we = 1'b1;
          state_d  = ALLOCATE;
          req_d    = 1'b0;
          we_d     = 1'b0;
          addr_d   = {req_tag_q, req_idx_q, OFFSET_W'(0)};
          data_d   = '0;
        end
      end
      ALLOCATE: begin
        // Request rises one cycle after entry when coming from a write-back.
        if (ack) begin
          line_we = 1'b1;
          state_d = IDLE;
          req_d   = 1'b0;
          addr_d  = '0;
        end else if (!mem_req_o) begin
          req_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      req_tag_q  <= '0;
      req_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_o  <= req_d;
      mem_we_o   <= we_d;
      mem_addr_o <= addr_d;
      mem_data_o <= data_d;
      if (miss) begin
        req_tag_q <= addr_tag;
        req_idx_q <= addr_idx;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a bench-side backing-memory ack model.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         MemRead_i, MemWrite_i;
  logic [31:0]  Addr_i, Write_Data_i, Read_Data_o;
  logic         memStall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  int passed = 0;
  int total  = 0;

  int          stalls;
  logic        saw_wb;
  logic [31:0] wb_addr, wb_word0, fetch_addr;

  localparam logic [255:0] FILL1 = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                                    32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
  localparam logic [255:0] FILL2 = {32'hB0000007, 32'hB0000006, 32'hB0000005, 32'hB0000004,
                                    32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
  localparam logic [255:0] FILL3 = {32'hC0000007, 32'hC0000006, 32'hC0000005, 32'hC0000004,
                                    32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
  localparam logic [255:0] FILL4 = {32'hD0000007, 32'hD0000006, 32'hD0000005, 32'hD0000004,
                                    32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};

  dcache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .Addr_i       (Addr_i),
    .Write_Data_i (Write_Data_i),
    .Read_Data_o  (Read_Data_o),
    .memStall_o   (memStall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Memory model: acks each request in its delay-th high cycle; runs until stall drops.
  task automatic serve(input int delay, output int n_stall, output logic wb,
                       output logic [31:0] wa, output logic [31:0] w0,
                       output logic [31:0] fa);
    int rcnt;
    rcnt    = 0;
    n_stall = 0;
    wb      = 1'b0;
    wa      = '0;
    w0      = '0;
    fa      = '0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!memStall_o) return;
      n_stall++;
      if (mem_req_o) begin
        rcnt++;
        if (mem_we_o) begin
          wb = 1'b1;
          wa = mem_addr_o;
          w0 = mem_data_o[31:0];
        end else begin
          fa = mem_addr_o;
        end
        if (rcnt == delay) begin
          mem_ack_i = 1'b1;
          rcnt      = 0;
        end
      end
      @(negedge clk_i);
      mem_ack_i = 1'b0;
    end
    total++;
    $error("FAIL serve_timeout: stall still %0b after 200 cycles, want 0", memStall_o);
  endtask

  initial begin
    rst_i        = 1'b1;
    MemRead_i    = 1'b0;
    MemWrite_i   = 1'b0;
    Addr_i       = '0;
    Write_Data_i = '0;
    mem_ack_i    = 1'b0;
    mem_data_i   = FILL1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_stall", 32'(memStall_o), 0);
    chk("rst_req",   32'(mem_req_o), 0);
    chk("rst_we",    32'(mem_we_o), 0);
    chk("rst_addr",  mem_addr_o, 0);
    chk("rst_data",  mem_data_o[31:0], 0);
    chk("rst_rdata", Read_Data_o, 0);

    // Cold load miss, ack in third request cycle
    @(negedge clk_i);
    MemRead_i = 1'b1;
    Addr_i    = 32'h40;
    #1;
    chk("cold_stall0", 32'(memStall_o), 1);
    chk("cold_rdata0", Read_Data_o, 0);
    serve(3, stalls, saw_wb, wb_addr, wb_word0, fetch_addr);
    chk("cold_stalls", 32'(stalls), 4);
    chk("cold_no_wb",  32'(saw_wb), 0);
    chk("cold_faddr",  fetch_addr, 32'h40);
    chk("cold_rdata",  Read_Data_o, 32'hDEADBEEF);

    // Back-to-back hits
    @(negedge clk_i);
    Addr_i = 32'h44;
    #1;
    chk("hit44_stall", 32'(memStall_o), 0);
    chk("hit44_rdata", Read_Data_o, 32'h11111111);
    @(negedge clk_i);
    Addr_i = 32'h48;
    #1;
    chk("hit48_stall", 32'(memStall_o), 0);
    chk("hit48_rdata", Read_Data_o, 32'h22222222);

    // Store hit, then conflicting load forces write-back
    @(negedge clk_i);
    MemRead_i    = 1'b0;
    MemWrite_i   = 1'b1;
    Addr_i       = 32'h40;
    Write_Data_i = 32'h12345678;
    #1;
    chk("st40_stall", 32'(memStall_o), 0);
    @(negedge clk_i);
    MemWrite_i = 1'b0;
    MemRead_i  = 1'b1;
    Addr_i     = 32'h440;
    mem_data_i = FILL2;
    serve(2, stalls, saw_wb, wb_addr, wb_word0, fetch_addr);
    chk("dirty_stalls", 32'(stalls), 6);
    chk("dirty_wb",     32'(saw_wb), 1);
    chk("dirty_waddr",  wb_addr, 32'h40);
    chk("dirty_wword",  wb_word0, 32'h12345678);
    chk("dirty_faddr",  fetch_addr, 32'h440);
    chk("dirty_rdata",  Read_Data_o, 32'hB0000000);

    // Line refilled clean: next conflict needs no write-back
    @(negedge clk_i);
    Addr_i = 32'h840;
    serve(1, stalls, saw_wb, wb_addr, wb_word0, fetch_addr);
    chk("clean_stalls", 32'(stalls), 2);
    chk("clean_no_wb",  32'(saw_wb), 0);
    chk("clean_faddr",  fetch_addr, 32'h840);

    // Store miss: allocate then merge
    @(negedge clk_i);
    MemRead_i    = 1'b0;
    MemWrite_i   = 1'b1;
    Addr_i       = 32'h80;
    Write_Data_i = 32'hCAFEF00D;
    mem_data_i   = FILL3;
    serve(1, stalls, saw_wb, wb_addr, wb_word0, fetch_addr);
    chk("stm_stalls", 32'(stalls), 2);
    chk("stm_no_wb",  32'(saw_wb), 0);
    chk("stm_faddr",  fetch_addr, 32'h80);
    @(negedge clk_i);
    MemWrite_i = 1'b0;
    MemRead_i  = 1'b1;
    #1;
    chk("stm_rd80", Read_Data_o, 32'hCAFEF00D);
    @(negedge clk_i);
    Addr_i = 32'h84;
    #1;
    chk("stm_rd84", Read_Data_o, 32'hC0000001);
    @(negedge clk_i);
    Addr_i = 32'h480;
    serve(1, stalls, saw_wb, wb_addr, wb_word0, fetch_addr);
    chk("stm_dirty_wb",    32'(saw_wb), 1);
    chk("stm_dirty_waddr", wb_addr, 32'h80);
    chk("stm_dirty_wword", wb_word0, 32'hCAFEF00D);
    chk("stm_dirty_stall", 32'(stalls), 4);
    chk("stm_refill_rd",   Read_Data_o, 32'hC0000000);

    // Reset while ALLOCATE request is pending; late ack must be ignored
    @(negedge clk_i);
    Addr_i = 32'hC0;
    #1;
    chk("rmid_stall0", 32'(memStall_o), 1);
    @(negedge clk_i);
    #1;
    chk("rmid_req", 32'(mem_req_o), 1);
    chk("rmid_addr", mem_addr_o, 32'hC0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i     = 1'b0;
    MemRead_i = 1'b0;
    #1;
    chk("rmid_req_after",   32'(mem_req_o), 0);
    chk("rmid_stall_after", 32'(memStall_o), 0);
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk("rmid_req_late",   32'(mem_req_o), 0);
    chk("rmid_stall_late", 32'(memStall_o), 0);
    MemRead_i = 1'b1;
    Addr_i    = 32'hC0;
    #1;
    chk("rmid_c0_miss", 32'(memStall_o), 1);
    Addr_i = 32'h840;
    #1;
    chk("rmid_840_miss",  32'(memStall_o), 1);
    chk("rmid_840_rdata", Read_Data_o, 0);
    mem_data_i = FILL4;
    serve(1, stalls, saw_wb, wb_addr, wb_word0, fetch_addr);
    chk("rmid_refill_stalls", 32'(stalls), 2);
    chk("rmid_refill_rdata",  Read_Data_o, 32'hD0000000);

    // Read and write together on a hit act as a store
    @(negedge clk_i);
    MemWrite_i   = 1'b1;
    Write_Data_i = 32'hA5A5A5A5;
    #1;
    chk("both_stall", 32'(memStall_o), 0);
    @(negedge clk_i);
    MemWrite_i = 1'b0;
    #1;
    chk("both_rdata", Read_Data_o, 32'hA5A5A5A5);
    @(negedge clk_i);
    Addr_i = 32'h40;
    serve(1, stalls, saw_wb, wb_addr, wb_word0, fetch_addr);
    chk("both_dirty_wb",    32'(saw_wb), 1);
    chk("both_dirty_waddr", wb_addr, 32'h840);
    chk("both_dirty_wword", wb_word0, 32'hA5A5A5A5);
    chk("both_dirty_stall", 32'(stalls), 4);

    @(negedge clk_i);
    MemRead_i = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
